fp_round_stage: RTL and testbench

- Two-stage pipelined rounding and packing stage downstream of the unrounded-result producers (sqrt, div, add, mul).
- Consumes a uround_res_t plus a done/valid strobe and applies the requested roundmode_e.
- Produces the final IEEE-754 encoding and a 5-bit exception flag vector {NV,DZ,OF,UF,NX}.
- Provides valid/ready backpressure and a sticky flag accumulator for the CSR side.

---
 rtl/fp_round_stage.sv | 148 ++++++++++++++
 tb/tb_fp_round_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fp_round_stage.sv
// rtl/fp_round_stage.sv - two-stage IEEE-754 rounding and packing stage with valid/ready and sticky flags
// urnd_i layout: {u_result[FP_WIDTH-1:0], rs[1:0], round_en, invalid, exp_cout[1:0]}; modes RNE=0 RTZ=1 RDN=2 RUP=3 RMM=4
module fp_round_stage #(
    parameter logic [1:0] FP_FORMAT = 2'd0,
    localparam int EXP_WIDTH  = (FP_FORMAT == 2'd1) ? 11 : (FP_FORMAT == 2'd2) ? 5 : 8,
    localparam int MANT_WIDTH = (FP_FORMAT == 2'd1) ? 52 : (FP_FORMAT == 2'd2) ? 10 :
                                (FP_FORMAT == 2'd3) ? 7 : 23,
    localparam int FP_WIDTH   = EXP_WIDTH + MANT_WIDTH + 1,
    localparam int URND_WIDTH = FP_WIDTH + 6
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [URND_WIDTH-1:0] urnd_i,
    input  logic [2:0]            rnd_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [FP_WIDTH-1:0]   result_o,
    output logic [4:0]            fflags_o,
    output logic [4:0]            fflags_acc_o,
    input  logic                  flags_clr_i
);
    localparam int E = EXP_WIDTH;
    localparam int M = MANT_WIDTH;
    localparam int W = FP_WIDTH;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RDN = 3'd2;
    localparam logic [2:0] RUP = 3'd3;
    localparam logic [2:0] RMM = 3'd4;

    logic [W-1:0] in_res;
    logic [1:0]   in_rs;
    logic         in_ren;
    logic         in_inv;
    logic [1:0]   in_cout;
    logic         in_inc;

    assign in_res  = urnd_i[W+5:6];
    assign in_rs   = urnd_i[5:4];
    assign in_ren  = urnd_i[3];
    assign in_inv  = urnd_i[2];
    assign in_cout = urnd_i[1:0];

    always_comb begin
        in_inc = 1'b0;
        if (in_ren) begin
            case (rnd_i)
                RTZ:     in_inc = 1'b0;
                RDN:     in_inc = in_res[W-1] & (in_rs[1] | in_rs[0]);
                RUP:     in_inc = !in_res[W-1] & (in_rs[1] | in_rs[0]);
                RMM:     in_inc = in_rs[1];
                default: in_inc = in_rs[1] & (in_rs[0] | in_res[0]);
            endcase
        end
    end

    logic         s1_valid;
    logic [W-1:0] s1_res;
    logic [2:0]   s1_mode;
    logic         s1_inc;
    logic         s1_ren;
    logic         s1_inv;
    logic [1:0]   s1_cout;
    logic         s1_rs_any;
    logic         s1_adv;
    logic         s2_adv;

    assign s2_adv  = !valid_o | ready_i;
    assign s1_adv  = !s1_valid | s2_adv;
    assign ready_o = s1_adv;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (valid_i && s1_adv) begin
            s1_res    <= in_res;
            s1_mode   <= rnd_i;
            s1_inc    <= in_inc;
            s1_ren    <= in_ren;
            s1_inv    <= in_inv;
            s1_cout   <= in_cout;
            s1_rs_any <= in_rs[1] | in_rs[0];
        end
    end

    logic [E+M:0] sum;
    logic         sign;
    logic         ovf;
    logic         to_inf;
    logic [W-1:0] next_res;
    logic [4:0]   next_flags;

    // A carry out of the full {exp,mant} field (all-ones input) is also an overflow.
    always_comb begin
        sign   = s1_res[W-1];
        sum    = {1'b0, s1_res[W-2:0]} + {{(E+M){1'b0}}, s1_inc};
        ovf    = s1_ren & (s1_cout[1] | sum[E+M] | (&sum[E+M-1 -: E]));
        to_inf = 1'b1;
        case (s1_mode)
            RTZ:     to_inf = 1'b0;
            RDN:     to_inf = sign;
            RUP:     to_inf = !sign;
            default: to_inf = 1'b1;
        endcase
        if (!s1_ren) begin
            next_res = s1_res;
        end else if (ovf) begin
            next_res = to_inf ? {sign, {E{1'b1}}, {M{1'b0}}}
                              : {sign, {(E-1){1'b1}}, 1'b0, {M{1'b1}}};
        end else begin
            next_res = {sign, sum[E+M-1:0]};
        end
        next_flags = {s1_inv, 1'b0, ovf,
                      s1_ren & s1_cout[0] & s1_rs_any,
                      (s1_ren & s1_rs_any) | ovf};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_o      <= 1'b0;
            result_o     <= '0;
            fflags_o     <= '0;
            fflags_acc_o <= '0;
        end else begin
            if (s2_adv) begin
                valid_o <= s1_valid;
                if (s1_valid) begin
                    result_o <= next_res;
                    fflags_o <= next_flags;
                end
            end
            if (valid_o && ready_i) begin
                fflags_acc_o <= flags_clr_i ? fflags_o : (fflags_acc_o | fflags_o);
            end else if (flags_clr_i) begin
                fflags_acc_o <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fp_round_stage.sv
// tb/tb_fp_round_stage.sv - directed scoreboard bench for fp_round_stage (FP32)
module tb_fp_round_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [37:0] urnd;
    logic [2:0]  rnd;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result;
    logic [4:0]  fflags;
    logic [4:0]  acc;
    logic        flags_clr;

    always #5 clk = ~clk;

    fp_round_stage dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .urnd_i       (urnd),
        .rnd_i        (rnd),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result),
        .fflags_o     (fflags),
        .fflags_acc_o (acc),
        .flags_clr_i  (flags_clr)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  fl;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    int   total = 0;
    int   bad = 0;
    int   outs = 0;
    int   outs0;
    int   sent;
    logic last_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t e;
        #1;
        if (valid_o && ready_i) begin
            chk("output_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("fflags", {27'b0, fflags}, {27'b0, e.fl});
            end
            outs++;
        end
        last_in = valid_i && ready_o;
        if (last_in) sb.push_back(pend);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] u, input logic [1:0] rs, input logic ren,
                        input logic inv, input logic [1:0] cout, input logic [2:0] mode,
                        input logic [31:0] er, input logic [4:0] ef);
        urnd     = {u, rs, ren, inv, cout};
        rnd      = mode;
        pend.res = er;
        pend.fl  = ef;
        valid_i  = 1'b1;
        tick();
        valid_i  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        flags_clr = 1'b0;
        urnd = '0;
        rnd = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_fflags", {27'b0, fflags}, 32'd0);
        chk("rst_acc", {27'b0, acc}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        @(posedge clk);
        #1;

        // latency: accepted at edge k, visible after edge k+1
        send(32'h3F800000, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0, 32'h3F800001, 5'h01);
        chk("lat_s1", {31'b0, valid_o}, 32'd0);
        tick();
        chk("lat_s2", {31'b0, valid_o}, 32'd1);

        send(32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, 3'd0, 32'h3F800000, 5'h01);
        send(32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, 3'd0, 32'h3F800002, 5'h01);
        send(32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0, 32'h7F800000, 5'h05);
        send(32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 3'd1, 32'h7F7FFFFF, 5'h01);
        send(32'hFF7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 3'd2, 32'hFF800000, 5'h05);
        send(32'hFF7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 3'd3, 32'hFF7FFFFF, 5'h01);
        send(32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 3'd3, 32'h7F800000, 5'h05);
        send(32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, 3'd4, 32'h3F800001, 5'h01);
        send(32'h3F800001, 2'b01, 1'b1, 1'b0, 2'b00, 3'd2, 32'h3F800001, 5'h01);
        send(32'h00000001, 2'b01, 1'b1, 1'b0, 2'b01, 3'd1, 32'h00000001, 5'h03);
        send(32'h3FFFFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0, 32'h40000000, 5'h01);
        send(32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, 3'd5, 32'h3F800002, 5'h01);
        send(32'h00000000, 2'b00, 1'b1, 1'b0, 2'b10, 3'd0, 32'h7F800000, 5'h05);
        send(32'h7F7FFFFF, 2'b00, 1'b1, 1'b0, 2'b10, 3'd1, 32'h7F7FFFFF, 5'h05);
        send(32'hFFC00000, 2'b11, 1'b0, 1'b1, 2'b00, 3'd0, 32'hFFC00000, 5'h10);
        drain();
        chk("acc_sticky", {27'b0, acc}, 32'h17);

        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        chk("acc_clr_alone", {27'b0, acc}, 32'd0);

        send(32'hFFC00000, 2'b00, 1'b0, 1'b1, 2'b00, 3'd0, 32'hFFC00000, 5'h10);
        drain();
        chk("acc_nv", {27'b0, acc}, 32'h10);
        send(32'h3F800000, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0, 32'h3F800001, 5'h01);
        tick();
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        chk("acc_clr_xfer", {27'b0, acc}, 32'h01);

        // backpressure: ready_i low for cycles 3..5 with both stages full
        sent = 0;
        outs0 = outs;
        for (int c = 0; c < 30 && (sent < 4 || sb.size() != 0); c++) begin
            ready_i = !(c >= 3 && c <= 5);
            valid_i = (sent < 4);
            urnd = {32'h3F800000 + 32'(sent) * 32'h10, 2'b11, 1'b1, 1'b0, 2'b00};
            rnd = 3'd0;
            pend.res = 32'h3F800001 + 32'(sent) * 32'h10;
            pend.fl = 5'h01;
            #1;
            if (c >= 3 && c <= 5) chk("bp_ready_low", {31'b0, ready_o}, 32'd0);
            if (c == 6) chk("bp_ready_high", {31'b0, ready_o}, 32'd1);
            tick();
            if (last_in) sent++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        chk("bp_sent", 32'(sent), 32'd4);
        chk("bp_outs", 32'(outs - outs0), 32'd4);
        chk("bp_empty", 32'(sb.size()), 32'd0);

        // reset with two results in flight
        send(32'h3F800000, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0, 32'h3F800001, 5'h01);
        send(32'h3F800010, 2'b11, 1'b1, 1'b0, 2'b00, 3'd0, 32'h3F800011, 5'h01);
        chk("pre_rst_valid", {31'b0, valid_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, valid_o}, 32'd0);
        chk("mid_rst_acc", {27'b0, acc}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        outs0 = outs;
        repeat (4) tick();
        chk("post_rst_valid", {31'b0, valid_o}, 32'd0);
        chk("post_rst_outs", 32'(outs - outs0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
